// File: rtl/div_req_ctrl.sv
// EX-stage initiator for the iterative divider: latches and extends operands, issues one request,
// then selects and W-extends the result. Optional result reuse is enabled by defining DIV_REUSE_EN.
module div_req_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [1:0]  div_op_i,
    input  logic        is_word_i,
    input  logic [63:0] rs1_i,
    input  logic [63:0] rs2_i,
    input  logic        flush_i,
    input  logic        hold_i,
    output logic        stall_o,
    output logic        result_valid_o,
    output logic [63:0] result_o,
    output logic        req_valid_o,
    output logic [63:0] op_1_o,
    output logic [63:0] op_2_o,
    output logic        sign_op_1_o,
    output logic        sign_op_2_o,
    input  logic [63:0] quotient_i,
    input  logic [63:0] remainder_i,
    input  logic        ready_i,
    input  logic        valid_i
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [63:0] op1_q, op1_d, op2_q, op2_d, result_q, result_d;
    logic        sign_q, sign_d, rem_q, rem_d, word_q, word_d;
    logic [63:0] op1Ext, op2Ext, divSel, hitResult;
    logic        hit;

    function automatic logic [63:0] wordExt(input logic [63:0] r, input logic w);
        return w ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

    always_comb begin
        op1Ext = rs1_i;
        op2Ext = rs2_i;
        if (is_word_i) begin
            op1Ext = div_op_i[0] ? {32'b0, rs1_i[31:0]} : {{32{rs1_i[31]}}, rs1_i[31:0]};
            op2Ext = div_op_i[0] ? {32'b0, rs2_i[31:0]} : {{32{rs2_i[31]}}, rs2_i[31:0]};
        end
    end

    assign divSel = rem_q ? remainder_i : quotient_i;

`ifdef DIV_REUSE_EN
    logic        saveValid_q;
    logic [63:0] saveOp1_q, saveOp2_q, saveQ_q, saveR_q;
    logic        saveWord_q, saveUns_q;

    // Tag uses the extended operands, so W forms differing only in rs[63:32] still hit correctly.
    always_ff @(posedge clk) begin
        if (rst) begin
            saveValid_q <= 1'b0;
            saveOp1_q   <= '0;
            saveOp2_q   <= '0;
            saveQ_q     <= '0;
            saveR_q     <= '0;
            saveWord_q  <= 1'b0;
            saveUns_q   <= 1'b0;
        end else if (state_q == WAIT && valid_i && !flush_i) begin
            saveValid_q <= 1'b1;
            saveOp1_q   <= op1_q;
            saveOp2_q   <= op2_q;
            saveQ_q     <= quotient_i;
            saveR_q     <= remainder_i;
            saveWord_q  <= word_q;
            saveUns_q   <= ~sign_q;
        end
    end

    assign hit = saveValid_q && op1Ext == saveOp1_q && op2Ext == saveOp2_q &&
                 is_word_i == saveWord_q && div_op_i[0] == saveUns_q;
    assign hitResult = wordExt(div_op_i[1] ? saveR_q : saveQ_q, is_word_i);
`else
    assign hit       = 1'b0;
    assign hitResult = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            sign_q   <= 1'b0;
            rem_q    <= 1'b0;
            word_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            sign_q   <= sign_d;
            rem_q    <= rem_d;
            word_q   <= word_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        sign_d   = sign_q;
        rem_d    = rem_q;
        word_d   = word_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (ex_valid_i && !flush_i) begin
                    if (hit) begin
                        result_d = hitResult;
                        state_d  = DONE;
                    end else if (ready_i) begin
                        op1_d   = op1Ext;
                        op2_d   = op2Ext;
                        sign_d  = ~div_op_i[0];
                        rem_d   = div_op_i[1];
                        word_d  = is_word_i;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = flush_i ? IDLE : WAIT;
            WAIT: begin
                // A flush coinciding with valid_i means the divider already finished; nothing to drain.
                if (flush_i) begin
                    state_d = valid_i ? IDLE : DRAIN;
                end else if (valid_i) begin
                    result_d = wordExt(divSel, word_q);
                    state_d  = DONE;
                end
            end
            DONE:  if (flush_i || !hold_i) state_d = IDLE;
            DRAIN: if (valid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_valid_o    = (state_q == ISSUE) && !flush_i;
    assign result_valid_o = (state_q == DONE) && !flush_i;
    assign result_o       = result_q;
    assign op_1_o         = op1_q;
    assign op_2_o         = op2_q;
    assign sign_op_1_o    = sign_q;
    assign sign_op_2_o    = sign_q;
    assign stall_o        = ex_valid_i && !flush_i && !(state_q == DONE && !hold_i);

endmodule

// File: tb/tb_div_req_ctrl.sv
// Directed self-checking bench for div_req_ctrl with a behavioural 66-state divider model.
// Define DIV_REUSE_EN to exercise the result-reuse path.
module tb_div_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i, is_word_i, flush_i, hold_i;
    logic [1:0]  div_op_i;
    logic [63:0] rs1_i, rs2_i;
    logic        stall_o, result_valid_o, req_valid_o, sign_op_1_o, sign_op_2_o;
    logic [63:0] result_o, op_1_o, op_2_o;
    logic [63:0] quotient_i, remainder_i;
    logic        ready_i, valid_i;
    int          divCnt;
    int          tests = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    div_req_ctrl dut (
        .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .div_op_i(div_op_i),
        .is_word_i(is_word_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
        .hold_i(hold_i), .stall_o(stall_o), .result_valid_o(result_valid_o),
        .result_o(result_o), .req_valid_o(req_valid_o), .op_1_o(op_1_o),
        .op_2_o(op_2_o), .sign_op_1_o(sign_op_1_o), .sign_op_2_o(sign_op_2_o),
        .quotient_i(quotient_i), .remainder_i(remainder_i), .ready_i(ready_i),
        .valid_i(valid_i)
    );

    function automatic logic [63:0] refQuot(input logic [63:0] a, input logic [63:0] b, input logic s);
        logic signed [63:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 64'd0) return '1;
        if (s && a == 64'h8000_0000_0000_0000 && b == '1) return a;
        return s ? 64'(sa / sb) : a / b;
    endfunction

    function automatic logic [63:0] refRem(input logic [63:0] a, input logic [63:0] b, input logic s);
        logic signed [63:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 64'd0) return a;
        if (s && a == 64'h8000_0000_0000_0000 && b == '1) return '0;
        return s ? 64'(sa % sb) : a % b;
    endfunction

    // Divider: state 1 the cycle after the request, valid_i in state 66, idle again afterwards.
    always @(posedge clk) begin
        if (rst) begin
            divCnt      <= 0;
            quotient_i  <= '0;
            remainder_i <= '0;
        end else if (divCnt == 0 && req_valid_o) begin
            divCnt      <= 1;
            quotient_i  <= refQuot(op_1_o, op_2_o, sign_op_1_o);
            remainder_i <= refRem(op_1_o, op_2_o, sign_op_1_o);
        end else if (divCnt == 66) begin
            divCnt <= 0;
        end else if (divCnt != 0) begin
            divCnt <= divCnt + 1;
        end
    end

    assign ready_i = (divCnt == 0);
    assign valid_i = (divCnt == 66);

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic word, input logic [63:0] a, input logic [63:0] b);
        ex_valid_i = 1'b1;
        div_op_i   = op;
        is_word_i  = word;
        rs1_i      = a;
        rs2_i      = b;
        flush_i    = 1'b0;
        hold_i     = 1'b0;
    endtask

    // Request expected reqAt cycles after the inputs appear, result 67 cycles after the request.
    task automatic runOp(input string tag, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                         input int reqAt, input int holdN,
                         input logic [63:0] expOp1, input logic [63:0] expOp2, input logic expSign);
        int done;
        logic [63:0] lastRes;
        done = reqAt + 67;
        @(negedge clk);
        applyStimulus(op, word, a, b);
        #1;
        checkOutput({tag, ".stall0"}, 64'(stall_o), 64'd1);
        checkOutput({tag, ".req0"}, 64'(req_valid_o), 64'd0);
        for (int k = 1; k <= done + holdN; k++) begin
            @(negedge clk);
            hold_i = (k >= done && k < done + holdN);
            #1;
            checkOutput({tag, ".req"}, 64'(req_valid_o), 64'(k == reqAt));
            checkOutput({tag, ".rvalid"}, 64'(result_valid_o), 64'(k >= done));
            checkOutput({tag, ".stall"}, 64'(stall_o), 64'(k < done + holdN));
            if (k == reqAt) begin
                checkOutput({tag, ".op1"}, op_1_o, expOp1);
                checkOutput({tag, ".op2"}, op_2_o, expOp2);
                checkOutput({tag, ".sign1"}, 64'(sign_op_1_o), 64'(expSign));
                checkOutput({tag, ".sign2"}, 64'(sign_op_2_o), 64'(expSign));
            end
            if (k >= done) checkOutput({tag, ".result"}, result_o, exp);
        end
        @(negedge clk);
        ex_valid_i = 1'b0;
        hold_i     = 1'b0;
        #1;
        checkOutput({tag, ".idleRvalid"}, 64'(result_valid_o), 64'd0);
        checkOutput({tag, ".idleStall"}, 64'(stall_o), 64'd0);
        checkOutput({tag, ".idleReq"}, 64'(req_valid_o), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(2'b00, 1'b0, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst.stall", 64'(stall_o), 64'd1);
        checkOutput("rst.req", 64'(req_valid_o), 64'd0);
        checkOutput("rst.rvalid", 64'(result_valid_o), 64'd0);
        checkOutput("rst.result", result_o, 64'd0);
        checkOutput("rst.op1", op_1_o, 64'd0);
        checkOutput("rst.op2", op_2_o, 64'd0);
        checkOutput("rst.sign", 64'(sign_op_1_o), 64'd0);
        @(negedge clk);
        rst        = 1'b0;
        ex_valid_i = 1'b0;
        #1;
        checkOutput("rst.stallOff", 64'(stall_o), 64'd0);

        runOp("div", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD,
              1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
        runOp("remu0", 2'b11, 1'b0, 64'd100, 64'd0, 64'd100, 1, 0, 64'd100, 64'd0, 1'b0);
        runOp("divu0", 2'b01, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 64'd5, 64'd0, 1'b0);
        runOp("divwOvf", 2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 1, 0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        runOp("remuw0", 2'b11, 1'b1, 64'h0000_0001_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
              1, 0, 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b0);

        // Flush in WAIT: the divider still runs to completion before the next op is accepted.
        @(negedge clk);
        applyStimulus(2'b00, 1'b0, 64'd1000, 64'd3);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            #1;
            checkOutput("flush.rvalid", 64'(result_valid_o), 64'd0);
        end
        @(negedge clk);
        flush_i    = 1'b1;
        ex_valid_i = 1'b0;
        #1;
        checkOutput("flush.stall", 64'(stall_o), 64'd0);
        checkOutput("flush.req", 64'(req_valid_o), 64'd0);
        runOp("postFlush", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2,
              58, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1);

        runOp("hold", 2'b01, 1'b0, 64'd50, 64'd5, 64'd10, 1, 3, 64'd50, 64'd5, 1'b0);

        runOp("div100", 2'b00, 1'b0, 64'd100, 64'd7, 64'd14, 1, 0, 64'd100, 64'd7, 1'b1);
`ifdef DIV_REUSE_EN
        @(negedge clk);
        applyStimulus(2'b10, 1'b0, 64'd100, 64'd7);
        #1;
        checkOutput("reuse.stall0", 64'(stall_o), 64'd1);
        checkOutput("reuse.req0", 64'(req_valid_o), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("reuse.rvalid", 64'(result_valid_o), 64'd1);
        checkOutput("reuse.result", result_o, 64'd2);
        checkOutput("reuse.req1", 64'(req_valid_o), 64'd0);
        checkOutput("reuse.stall1", 64'(stall_o), 64'd0);
        @(negedge clk);
        ex_valid_i = 1'b0;
        #1;
        checkOutput("reuse.idle", 64'(result_valid_o), 64'd0);
`else
        runOp("rem100", 2'b10, 1'b0, 64'd100, 64'd7, 64'd2, 1, 0, 64'd100, 64'd7, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
